// File: rtl/pellet_map.sv
// rtl/pellet_map.sv - pellet occupancy store: ROM init sweep, CPU read/clear, video read, pellets-left count
// Optional power-pellet plane enabled by defining POWER_PELLET_EN.
module pellet_map #(
    parameter int MAP_W = 32,
    parameter int MAP_H = 32,
    parameter int CNT_W = 11
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [$clog2(MAP_W)-1:0]             cpu_x,
    input  logic [$clog2(MAP_H)-1:0]             cpu_y,
    input  logic                                 clr_req,
    input  logic                                 reload_req,
    output logic                                 pellet_data,
    output logic                                 eaten,
    output logic [$clog2(MAP_W*MAP_H)-1:0]       rom_addr,
    input  logic                                 rom_bit,
    input  logic [$clog2(MAP_W)-1:0]             vid_x,
    input  logic [$clog2(MAP_H)-1:0]             vid_y,
    output logic                                 vid_pellet,
    output logic [CNT_W-1:0]                     remaining,
    output logic                                 all_clear,
`ifdef POWER_PELLET_EN
    input  logic                                 rom_pwr,
    output logic                                 pwr_data,
    output logic                                 pwr_eaten,
`endif
    output logic                                 busy
);

    localparam int XW = $clog2(MAP_W);
    localparam int YW = $clog2(MAP_H);
    localparam int AW = XW + YW;
    localparam int N  = MAP_W * MAP_H;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    typedef enum logic [1:0] {S_INIT, S_FLUSH, S_IDLE} state_t;
    state_t state, state_nx;

    logic          mem [N];
    logic [AW-1:0] prev_addr;
    logic          prev_vld;
    logic [AW-1:0] cpu_a;
    logic [AW-1:0] vid_a;
    logic          clr_hit;
    logic          init_wr;

    assign cpu_a   = {cpu_y, cpu_x};
    assign vid_a   = {vid_y, vid_x};
    // ROM data lags the address by a cycle, so the sweep writes the previously presented address
    assign init_wr = prev_vld && !reload_req;
    assign clr_hit = (state == S_IDLE) && !reload_req && clr_req && mem[cpu_a];

    always_ff @(posedge clk) begin
        if (reset) state <= S_INIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (reload_req) begin
            state_nx = S_INIT;
        end else begin
            case (state)
                S_INIT:  if (rom_addr == LAST) state_nx = S_FLUSH;
                S_FLUSH: state_nx = S_IDLE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_wr)      mem[prev_addr] <= rom_bit;
            else if (clr_hit) mem[cpu_a]     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr    <= '0;
            prev_addr   <= '0;
            prev_vld    <= 1'b0;
            remaining   <= '0;
            busy        <= 1'b1;
            eaten       <= 1'b0;
            pellet_data <= 1'b0;
            vid_pellet  <= 1'b0;
            all_clear   <= 1'b0;
        end else begin
            prev_addr   <= rom_addr;
            prev_vld    <= (state == S_INIT) && !reload_req;
            busy        <= (state_nx != S_IDLE);
            eaten       <= clr_hit;
            // a cleared cell reads 0 on the CPU port from the very next cycle
            pellet_data <= mem[cpu_a] & ~clr_hit;
            vid_pellet  <= (state == S_IDLE) & mem[vid_a];
            all_clear   <= (state == S_IDLE) && !reload_req && (remaining == '0);
            if (reload_req) begin
                rom_addr  <= '0;
                remaining <= '0;
            end else begin
                if (state == S_INIT)
                    rom_addr <= (rom_addr == LAST) ? '0 : rom_addr + AW'(1);
                if (init_wr && rom_bit)
                    remaining <= remaining + CNT_W'(1);
                else if (clr_hit && remaining != '0)
                    remaining <= remaining - CNT_W'(1);
            end
        end
    end

`ifdef POWER_PELLET_EN
    logic pmem [N];

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_wr)      pmem[prev_addr] <= rom_pwr;
            else if (clr_hit) pmem[cpu_a]     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwr_data  <= 1'b0;
            pwr_eaten <= 1'b0;
        end else begin
            pwr_data  <= pmem[cpu_a] & ~clr_hit;
            pwr_eaten <= clr_hit & pmem[cpu_a];
        end
    end
`endif

endmodule
